cc_sar_search: RTL and testbench

- Successive-approximation controller that drives the operand side of an external magnitude comparator and consumes its 1-bit result.
- Finds the largest unsigned code T such that T <= the value on the comparator's other input (i.e. quantizes a neuron membrane/accumulator value by binary search).
- Sits in the neuron datapath between the accumulator and the output stage.
- Comparator contract: result = 1 when trial (c0) <= reference (c1), else 0.

---
 rtl/cc_sar_search_pkg.sv | 13 +
 rtl/cc_sar_settle_timer.sv | 31 +++
 rtl/cc_sar_search.sv | 109 ++++++++++
 tb/tb_cc_sar_search.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cc_sar_search_pkg.sv
// Shared types and constants for the SAR quantizer and its settle timer.
package cc_sar_search_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } sarState_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int SETTLE_WIDTH  = 4;

endpackage

// File: rtl/cc_sar_settle_timer.sv
// Loadable up/down counter with a terminal-match flag, used to pace comparator settling.
module cc_sar_settle_timer
  import cc_sar_search_pkg::*;
#(
  parameter int WIDTH = SETTLE_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] loadValue,
  input  logic             countEn,
  input  logic             countUp,
  input  logic [WIDTH-1:0] terminalValue,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (countEn) begin
      count <= countUp ? count + 1'b1 : count - 1'b1;
    end
  end

  assign terminal = (count == terminalValue);

endmodule

// File: rtl/cc_sar_search.sv
// Successive-approximation controller: binary-searches the largest code <= the comparator reference.
// Optional macro CC_SAR_SEARCH_CONTINUOUS_EN restarts a conversion straight out of DONE.
module cc_sar_search
  import cc_sar_search_pkg::*;
#(
  parameter int NUMBER_DATAWIDTH = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES    = 0
) (
  input  logic                        CC_SAR_SEARCH_CLOCK_50,
  input  logic                        CC_SAR_SEARCH_RESET_InLow,
  input  logic                        CC_SAR_SEARCH_start_InLow,
  input  logic                        CC_SAR_SEARCH_cmp_In,
  output logic [NUMBER_DATAWIDTH-1:0] CC_SAR_SEARCH_trial_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_SAR_SEARCH_result_OutBUS,
  output logic                        CC_SAR_SEARCH_busy_Out,
  output logic                        CC_SAR_SEARCH_done_Out
);

  localparam int IDX_W = (NUMBER_DATAWIDTH > 1) ? $clog2(NUMBER_DATAWIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUMBER_DATAWIDTH - 1);
  localparam logic [NUMBER_DATAWIDTH-1:0] TRIAL_MSB =
    NUMBER_DATAWIDTH'(1) << (NUMBER_DATAWIDTH - 1);
  localparam logic [SETTLE_WIDTH-1:0] SETTLE_LIMIT = SETTLE_WIDTH'(SETTLE_CYCLES);

  sarState_t                   state;
  logic [IDX_W-1:0]            idx;
  logic [NUMBER_DATAWIDTH-1:0] decided;
  logic [NUMBER_DATAWIDTH-1:0] nextTrial;
  logic [SETTLE_WIDTH-1:0]     settleCount;
  logic                        settleDone;
  logic                        settleLoad;
  logic                        settleEn;

  // Counter sits at zero outside SAMPLE and is re-zeroed at every decision edge.
  assign settleLoad = (state != SAMPLE) || settleDone;
  assign settleEn   = (state == SAMPLE) && !settleDone;

  cc_sar_settle_timer #(.WIDTH(SETTLE_WIDTH)) u_settle (
    .clk           (CC_SAR_SEARCH_CLOCK_50),
    .rst_n         (CC_SAR_SEARCH_RESET_InLow),
    .load          (settleLoad),
    .loadValue     ('0),
    .countEn       (settleEn),
    .countUp       (1'b1),
    .terminalValue (SETTLE_LIMIT),
    .count         (settleCount),
    .terminal      (settleDone)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    decided      = CC_SAR_SEARCH_trial_OutBUS;
    decided[idx] = CC_SAR_SEARCH_cmp_In;
    nextTrial    = decided;
    if (idx != '0) nextTrial[idx - 1'b1] = 1'b1;
  end

  always_ff @(posedge CC_SAR_SEARCH_CLOCK_50 or negedge CC_SAR_SEARCH_RESET_InLow) begin
    if (!CC_SAR_SEARCH_RESET_InLow) begin
      state                       <= IDLE;
      idx                         <= IDX_TOP;
      CC_SAR_SEARCH_trial_OutBUS  <= '0;
      CC_SAR_SEARCH_result_OutBUS <= '0;
      CC_SAR_SEARCH_busy_Out      <= 1'b0;
      CC_SAR_SEARCH_done_Out      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          CC_SAR_SEARCH_done_Out <= 1'b0;
          CC_SAR_SEARCH_busy_Out <= 1'b0;
          if (!CC_SAR_SEARCH_start_InLow) begin
            CC_SAR_SEARCH_trial_OutBUS <= TRIAL_MSB;
            idx                        <= IDX_TOP;
            CC_SAR_SEARCH_busy_Out     <= 1'b1;
            state                      <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (settleDone) begin
            if (idx == '0) begin
              CC_SAR_SEARCH_trial_OutBUS  <= decided;
              CC_SAR_SEARCH_result_OutBUS <= decided;
              CC_SAR_SEARCH_busy_Out      <= 1'b0;
              CC_SAR_SEARCH_done_Out      <= 1'b1;
              state                       <= DONE;
            end else begin
              CC_SAR_SEARCH_trial_OutBUS <= nextTrial;
              idx                        <= idx - 1'b1;
            end
          end
        end
        DONE: begin
          CC_SAR_SEARCH_done_Out <= 1'b0;
`ifdef CC_SAR_SEARCH_CONTINUOUS_EN
          CC_SAR_SEARCH_trial_OutBUS <= TRIAL_MSB;
          idx                        <= IDX_TOP;
          CC_SAR_SEARCH_busy_Out     <= 1'b1;
          state                      <= SAMPLE;
`else
          CC_SAR_SEARCH_busy_Out     <= 1'b0;
          state                      <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_sar_search.sv
// Bench for cc_sar_search: two instances (settle 0 and settle 2) checked every cycle against a binary-search model.
module tb_cc_sar_search;

  localparam int W = 8;
  localparam int SETTLE [2] = '{0, 2};

  logic       clk;
  logic       rst_n;
  logic       startN [2];
  logic [7:0] refV   [2];
  logic       cmpW   [2];
  logic [7:0] trialW [2];
  logic [7:0] resW   [2];
  logic       busyW  [2];
  logic       doneW  [2];

  int passCount  = 0;
  int checkCount = 0;

  // Behavioural model state: n = -1 when idle, else cycles since the start edge.
  int         n        [2] = '{-1, -1};
  logic [7:0] convRef  [2];
  logic [7:0] lastRes  [2] = '{8'h00, 8'h00};
  logic [7:0] lastTrial[2] = '{8'h00, 8'h00};
  logic [7:0] trace    [32];
  int         lat;

  assign cmpW[0] = (trialW[0] <= refV[0]);
  assign cmpW[1] = (trialW[1] <= refV[1]);

  cc_sar_search #(.NUMBER_DATAWIDTH(W), .SETTLE_CYCLES(0)) dut0 (
    .CC_SAR_SEARCH_CLOCK_50      (clk),
    .CC_SAR_SEARCH_RESET_InLow   (rst_n),
    .CC_SAR_SEARCH_start_InLow   (startN[0]),
    .CC_SAR_SEARCH_cmp_In        (cmpW[0]),
    .CC_SAR_SEARCH_trial_OutBUS  (trialW[0]),
    .CC_SAR_SEARCH_result_OutBUS (resW[0]),
    .CC_SAR_SEARCH_busy_Out      (busyW[0]),
    .CC_SAR_SEARCH_done_Out      (doneW[0])
  );

  cc_sar_search #(.NUMBER_DATAWIDTH(W), .SETTLE_CYCLES(2)) dut1 (
    .CC_SAR_SEARCH_CLOCK_50      (clk),
    .CC_SAR_SEARCH_RESET_InLow   (rst_n),
    .CC_SAR_SEARCH_start_InLow   (startN[1]),
    .CC_SAR_SEARCH_cmp_In        (cmpW[1]),
    .CC_SAR_SEARCH_trial_OutBUS  (trialW[1]),
    .CC_SAR_SEARCH_result_OutBUS (resW[1]),
    .CC_SAR_SEARCH_busy_Out      (busyW[1]),
    .CC_SAR_SEARCH_done_Out      (doneW[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Model: after j decided bits the trial is the reference's top j bits plus the next probe bit.
  always @(negedge clk) begin
    int L, j;
    logic [7:0] expT;
    for (int d = 0; d < 2; d++) begin
      L = W * (SETTLE[d] + 1);
      if (!rst_n) begin
        n[d] = -1; lastRes[d] = 8'h00; lastTrial[d] = 8'h00;
      end else if (n[d] == -1) begin
        if (!startN[d]) begin n[d] = 0; convRef[d] = refV[d]; end
      end else if (n[d] < L) begin
        n[d]++;
        if (n[d] == L) begin lastRes[d] = convRef[d]; lastTrial[d] = convRef[d]; end
      end else begin
`ifdef CC_SAR_SEARCH_CONTINUOUS_EN
        n[d] = 0; convRef[d] = refV[d];
`else
        n[d] = -1;
`endif
      end

      if (n[d] == -1) begin
        check($sformatf("d%0d_idle_trial", d), trialW[d], lastTrial[d]);
        check($sformatf("d%0d_idle_busy", d), busyW[d], 0);
        check($sformatf("d%0d_idle_done", d), doneW[d], 0);
      end else if (n[d] < L) begin
        j    = n[d] / (SETTLE[d] + 1);
        expT = (convRef[d] & ~(8'hFF >> j)) | (8'h80 >> j);
        check($sformatf("d%0d_conv_trial", d), trialW[d], expT);
        check($sformatf("d%0d_conv_busy", d), busyW[d], 1);
        check($sformatf("d%0d_conv_done", d), doneW[d], 0);
      end else begin
        check($sformatf("d%0d_done_trial", d), trialW[d], convRef[d]);
        check($sformatf("d%0d_done_busy", d), busyW[d], 0);
        check($sformatf("d%0d_done_done", d), doneW[d], 1);
      end
      check($sformatf("d%0d_result", d), resW[d], lastRes[d]);
    end
  end

  // Starts a conversion, keeps start low for `hold` edges, returns edges from start to done.
  task automatic runConv(input int d, input logic [7:0] r, input int hold, output int latency);
    @(negedge clk); #1;
    refV[d]   = r;
    startN[d] = 1'b0;
    latency   = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k <= 32) trace[k-1] = trialW[d];
      if (doneW[d]) latency = k - 1;
      if (k >= hold && startN[d] == 1'b0) begin #1; startN[d] = 1'b1; end
      if (latency >= 0) break;
    end
    if (latency < 0) check($sformatf("d%0d_done_timeout", d), 0, 1);
    startN[d] = 1'b1;
  endtask

  initial begin
    logic [7:0] seqA5 [8];
    int doneSeen;
    seqA5 = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    rst_n = 1'b0;
    startN = '{1'b1, 1'b1};
    refV   = '{8'h00, 8'h00};
    repeat (3) @(negedge clk);
    check("reset_trial", trialW[0], 0);
    check("reset_result", resW[0], 0);
    check("reset_busy", busyW[0], 0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef CC_SAR_SEARCH_CONTINUOUS_EN
    runConv(0, 8'h5A, 1, lat);
    check("cont_lat_first", lat, 8);
    check("cont_result_5A", resW[0], 8'h5A);
    #1 refV[0] = 8'h12;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (doneW[0]) begin lat = k; break; end
    end
    check("cont_period", lat, 9);
    check("cont_result_12", resW[0], 8'h12);
    repeat (3) @(negedge clk);
`else
    runConv(0, 8'hA5, 1, lat);
    check("lat_A5", lat, 8);
    for (int i = 0; i < 8; i++) check($sformatf("seq_A5_%0d", i), trace[i], seqA5[i]);
    check("result_A5", resW[0], 8'hA5);
    @(negedge clk);
    check("done_one_cycle", doneW[0], 0);

    runConv(0, 8'h00, 1, lat);
    check("result_00", resW[0], 8'h00);
    runConv(0, 8'hFF, 1, lat);
    check("result_FF", resW[0], 8'hFF);
    check("busy_low_in_done", busyW[0], 0);

    runConv(1, 8'h3C, 1, lat);
    check("lat_settle2", lat, 24);
    check("settle_hold_1", trace[2], 8'h80);
    check("settle_second_trial", trace[3], 8'h40);
    check("result_3C", resW[1], 8'h3C);

    // Start held low through DONE: exactly one conversion.
    runConv(0, 8'h33, 9, lat);
    check("held_result", resW[0], 8'h33);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (doneW[0]) doneSeen++;
    end
    check("held_no_second_done", doneSeen, 0);

    // Reset mid-conversion discards the search.
    @(negedge clk); #1;
    refV[0] = 8'h77; startN[0] = 1'b0;
    @(negedge clk); #1 startN[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_trial", trialW[0], 0);
    check("async_rst_result", resW[0], 0);
    check("async_rst_busy", busyW[0], 0);
    check("async_rst_done", doneW[0], 0);
    @(negedge clk); #1 rst_n = 1'b1;
    runConv(0, 8'h77, 1, lat);
    check("lat_77", lat, 8);
    check("result_77", resW[0], 8'h77);
    repeat (3) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
